// File: rtl/pic_pkg.sv
// Shared encodings for the 14-bit-instruction sequencer: FSM states, opcode
// classes, ALU codes that influence sequencing, and fixed instruction words.
package pic_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } state_e;

  localparam logic [1:0] OP_BYTE = 2'b00;
  localparam logic [1:0] OP_BIT  = 2'b01;
  localparam logic [1:0] OP_CTRL = 2'b10;
  localparam logic [1:0] OP_LIT  = 2'b11;

  localparam logic [3:0] ALU_PASS_B = 4'b0000;
  localparam logic [3:0] ALU_BCF    = 4'b0100;
  localparam logic [3:0] ALU_BSF    = 4'b0101;
  localparam logic [3:0] ALU_BTFSC  = 4'b0110;
  localparam logic [3:0] ALU_BTFSS  = 4'b0111;
  localparam logic [3:0] ALU_DECFSZ = 4'b1011;
  localparam logic [3:0] ALU_INCFSZ = 4'b1111;

  localparam logic [13:0] INSTR_NOP    = 14'h0000;
  localparam logic [13:0] INSTR_RETURN = 14'h0008;

  // Byte-oriented ops that skip the next instruction on a zero result.
  function automatic logic is_byte_skip(input logic [3:0] op);
    return (op == ALU_DECFSZ) || (op == ALU_INCFSZ);
  endfunction

endpackage

// File: rtl/pic_return_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry,
// a pop when empty still reads the slot below the pointer; both cases are
// recorded in sticky flags that clear only on reset.
module pic_return_stack
  import pic_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int PC_W        = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] din_i,
  output logic [PC_W-1:0] dout_o,
  output logic            ovf_o,
  output logic            unf_o
);

  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(STACK_DEPTH);

  logic [PC_W-1:0]  mem_q [STACK_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W:0]   depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  assign top_idx = ptr_q - PTR_W'(1);
  assign dout_o  = mem_q[top_idx];
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

  // Push wins if both are requested; the sequencer never asks for both.
  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (depth_q == FULL) ovf_d = 1'b1;
      else                 depth_d = depth_q + (PTR_W+1)'(1);
    end else if (pop_i) begin
      ptr_d = top_idx;
      if (depth_q == '0) unf_d = 1'b1;
      else               depth_d = depth_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entries are plain storage and are not cleared by reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q] <= din_i;
  end

endmodule

// File: rtl/pic_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC and return stack, issues fetches
// and drives one-cycle W/register-file write strobes on a fixed 3-cycle beat.
module pic_sequencer
  import pic_pkg::*;
#(
  parameter int              PC_W         = 13,
  parameter int              STACK_DEPTH  = 8,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [13:0]     imem_data,
  output logic [3:0]      alu_op,
  output logic [2:0]      bit_sel,
  output logic [7:0]      lit,
  output logic            sel_lit,
  output logic [6:0]      f_addr,
  output logic            w_we,
  output logic            f_we,
  input  logic            alu_zero,
  output logic [PC_W-1:0] pc,
  output logic            retired,
  output logic            stk_ovf,
  output logic            stk_unf
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [13:0]     ir_q, ir_d;

  logic [1:0]      op_class;
  logic [3:0]      alu_op_dec;
  logic            sel_lit_dec;
  logic            w_wr, f_wr;
  logic            skip, do_push, do_pop, do_jump;
  logic            exec_fire;
  logic [PC_W-1:0] pc_inc1, pc_inc2, jump_target, stk_dout;

  assign op_class    = ir_q[13:12];
  assign pc_inc1     = pc_q + PC_W'(1);
  assign pc_inc2     = pc_q + PC_W'(2);
  // Jumps stay within the current 2K page: upper PC bits are kept.
  assign jump_target = {pc_q[PC_W-1:11], ir_q[10:0]};

  always_comb begin
    alu_op_dec  = ir_q[11:8];
    sel_lit_dec = 1'b0;
    w_wr        = 1'b0;
    f_wr        = 1'b0;
    skip        = 1'b0;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    do_jump     = 1'b0;
    case (op_class)
      OP_BYTE: begin
        if (ir_q == INSTR_RETURN) begin
          do_pop = 1'b1;
        end else if (ir_q != INSTR_NOP) begin
          if (ir_q[7]) f_wr = 1'b1;
          else         w_wr = 1'b1;
          if (is_byte_skip(ir_q[11:8])) skip = alu_zero;
        end
      end
      OP_BIT: begin
        alu_op_dec = {2'b01, ir_q[11:10]};
        case (alu_op_dec)
          ALU_BCF, ALU_BSF: f_wr = 1'b1;
          ALU_BTFSC:        skip = alu_zero;
          ALU_BTFSS:        skip = ~alu_zero;
          default:          ;
        endcase
      end
      OP_CTRL: begin
        do_jump = 1'b1;
        do_push = ~ir_q[11];
      end
      default: begin
        sel_lit_dec = 1'b1;
        w_wr        = 1'b1;
        // RETLW: pass the literal straight into W and return.
        if (ir_q[11:10] == 2'b01) begin
          alu_op_dec = ALU_PASS_B;
          do_pop     = 1'b1;
        end
      end
    endcase
  end

  // Any strobe is suppressed in a reset cycle so an aborted instruction has no effect.
  assign exec_fire = (state_q == EXEC) && !rst;
  assign imem_en   = (state_q == FETCH) && run && !rst;
  assign imem_addr = pc_q;
  assign w_we      = exec_fire && w_wr;
  assign f_we      = exec_fire && f_wr;
  assign retired   = exec_fire;
  assign alu_op    = alu_op_dec;
  assign sel_lit   = sel_lit_dec;
  assign bit_sel   = ir_q[9:7];
  assign lit       = ir_q[7:0];
  assign f_addr    = ir_q[6:0];
  assign pc        = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH:  if (run) state_d = DECODE;
      DECODE: begin
        ir_d    = imem_data;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        if (do_pop)       pc_d = stk_dout;
        else if (do_jump) pc_d = jump_target;
        else if (skip)    pc_d = pc_inc2;
        else              pc_d = pc_inc1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_VECTOR;
      ir_q    <= 14'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  pic_return_stack #(
    .STACK_DEPTH(STACK_DEPTH),
    .PC_W       (PC_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push_i(exec_fire && do_push),
    .pop_i (exec_fire && do_pop),
    .din_i (pc_inc1),
    .dout_o(stk_dout),
    .ovf_o (stk_ovf),
    .unf_o (stk_unf)
  );

endmodule

// File: tb/tb_pic_sequencer.sv
// Bench for pic_sequencer: directed scenarios followed by random instruction
// streams, all checked against an instruction-level model of the sequencer.
module tb_pic_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic        imem_en;
  logic [12:0] imem_addr;
  logic [13:0] imem_data;
  logic [3:0]  alu_op;
  logic [2:0]  bit_sel;
  logic [7:0]  lit;
  logic        sel_lit;
  logic [6:0]  f_addr;
  logic        w_we;
  logic        f_we;
  logic        alu_zero;
  logic [12:0] pc;
  logic        retired;
  logic        stk_ovf;
  logic        stk_unf;

  int checks   = 0;
  int failures = 0;

  logic [13:0] imem [0:8191];

  // Model state: architectural PC and a circular 8-entry return stack.
  logic [12:0] mpc;
  logic [12:0] mstk [8];
  int          mptr;
  int          mdepth;
  logic        movf;
  logic        munf;

  pic_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .imem_en  (imem_en),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .alu_op   (alu_op),
    .bit_sel  (bit_sel),
    .lit      (lit),
    .sel_lit  (sel_lit),
    .f_addr   (f_addr),
    .w_we     (w_we),
    .f_we     (f_we),
    .alu_zero (alu_zero),
    .pc       (pc),
    .retired  (retired),
    .stk_ovf  (stk_ovf),
    .stk_unf  (stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) imem_data <= imem[imem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mpc    = 13'h0000;
    mptr   = 0;
    mdepth = 0;
    movf   = 1'b0;
    munf   = 1'b0;
  endtask

  // Run one instruction through FETCH/DECODE/EXEC. Entered and left just after
  // a falling edge with the DUT in FETCH and run=1.
  task automatic step(input logic [13:0] instr, input logic az);
    logic [1:0]  cls;
    logic [3:0]  aop;
    logic        ew, ef, sl, skip, push, pop, jump;
    logic [12:0] pv, npc;
    imem[mpc] = instr;
    chk("fetch_en", imem_en, 1);
    chk("fetch_addr", imem_addr, mpc);
    chk("fetch_pc", pc, mpc);
    chk("fetch_strobes", {w_we, f_we, retired}, 0);
    @(negedge clk); #1;
    chk("decode_strobes", {imem_en, w_we, f_we, retired}, 0);
    alu_zero = az;
    @(negedge clk); #1;

    cls = instr[13:12]; aop = instr[11:8];
    ew = 0; ef = 0; sl = 0; skip = 0; push = 0; pop = 0; jump = 0;
    if (instr == 14'h0000) begin
      // NOP
    end else if (instr == 14'h0008) begin
      pop = 1;
    end else if (cls == 2'b00) begin
      if (instr[7]) ef = 1; else ew = 1;
      if (aop == 4'hB || aop == 4'hF) skip = az;
    end else if (cls == 2'b01) begin
      aop = {2'b01, instr[11:10]};
      if (instr[11] == 1'b0) ef = 1;
      else if (instr[10] == 1'b0) skip = az;
      else skip = !az;
    end else if (cls == 2'b10) begin
      jump = 1;
      push = !instr[11];
    end else begin
      sl = 1; ew = 1;
      if (instr[11:10] == 2'b01) begin
        aop = 4'h0;
        pop = 1;
      end
    end

    chk("exec_w_we", w_we, ew);
    chk("exec_f_we", f_we, ef);
    chk("exec_retired", retired, 1);
    chk("exec_imem_en", imem_en, 0);
    if (cls != 2'b10) chk("exec_alu_op", alu_op, aop);
    chk("exec_sel_lit", sel_lit, sl);
    chk("exec_lit", lit, instr[7:0]);
    chk("exec_f_addr", f_addr, instr[6:0]);
    chk("exec_bit_sel", bit_sel, instr[9:7]);

    pv = 13'h0000;
    if (push) begin
      mstk[mptr] = 13'(mpc + 1);
      mptr = (mptr + 1) % 8;
      if (mdepth == 8) movf = 1'b1;
      else mdepth++;
    end
    if (pop) begin
      mptr = (mptr + 7) % 8;
      pv = mstk[mptr];
      if (mdepth == 0) munf = 1'b1;
      else mdepth--;
    end
    if (pop) npc = pv;
    else if (jump) npc = {mpc[12:11], instr[10:0]};
    else npc = 13'(mpc + (skip ? 2 : 1));
    mpc = npc;

    @(negedge clk); #1;
    chk("next_pc", pc, mpc);
    chk("stk_ovf", stk_ovf, movf);
    chk("stk_unf", stk_unf, munf);
  endtask

  task automatic idle(input int n);
    run = 1'b0;
    #1;
    for (int i = 0; i < n; i++) begin
      chk("idle_imem_en", imem_en, 0);
      chk("idle_retired", retired, 0);
      chk("idle_pc", pc, mpc);
      @(negedge clk); #1;
    end
    run = 1'b1;
    #1;
  endtask

  task automatic goto_top();
    for (int i = 0; i < 8; i++) begin
      if (mpc != 13'h1FFF) begin
        if (mpc[10:0] == 11'h7FF) step(14'h0000, 1'b0);
        else step(14'h2FFF, 1'b0);
      end
    end
    chk("reach_1fff", pc, 13'h1FFF);
  endtask

  initial begin
    logic [31:0] r;
    logic [13:0] ins;
    for (int i = 0; i < 8192; i++) imem[i] = 14'h0000;
    for (int i = 0; i < 8; i++) mstk[i] = 13'h0000;
    imem_data = 14'h0000;
    alu_zero  = 1'b0;
    run       = 1'b1;
    rst       = 1'b1;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_pc", pc, 13'h0000);
    chk("rst_strobes", {imem_en, w_we, f_we, retired}, 0);
    chk("rst_flags", {stk_ovf, stk_unf}, 0);
    chk("rst_lit", lit, 8'h00);
    rst = 1'b0;
    #1;

    // Literal op, then GOTO 5, then run held low.
    step(14'h3005, 1'b0);
    step(14'h2805, 1'b0);
    chk("goto5_pc", pc, 13'h0005);
    idle(4);

    // DECFSZ at pc=2 with and without the zero result.
    step(14'h2802, 1'b0);
    step(14'h0B20, 1'b1);
    chk("decfsz_skip_pc", pc, 13'h0004);
    step(14'h2802, 1'b0);
    step(14'h0B20, 1'b0);
    chk("decfsz_noskip_pc", pc, 13'h0003);

    // Bit tests.
    step(14'h1820, 1'b1);
    chk("btfsc_pc", pc, 13'h0005);
    step(14'h1C20, 1'b1);
    chk("btfss_pc", pc, 13'h0006);

    // CALL/RETURN, then overflow and underflow.
    step(14'h2810, 1'b0);
    step(14'h2100, 1'b0);
    chk("call_pc", pc, 13'h0100);
    step(14'h0008, 1'b0);
    chk("return_pc", pc, 13'h0011);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("pre_ovf", stk_ovf, 0);
      step(14'(14'h2200 + i), 1'b0);
    end
    chk("ovf_after_9_calls", stk_ovf, 1);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("pre_unf", stk_unf, 0);
      step(14'h0008, 1'b0);
    end
    chk("unf_after_9_returns", stk_unf, 1);

    // Page-preserving GOTO and PC wrap.
    goto_top();
    step(14'h2800, 1'b0);
    chk("goto_page_pc", pc, 13'h1800);
    goto_top();
    step(14'h0000, 1'b0);
    chk("wrap1_pc", pc, 13'h0000);
    goto_top();
    step(14'h0FA0, 1'b1);
    chk("wrap2_pc", pc, 13'h0001);

    // Reset during EXEC of a literal op.
    imem[mpc] = 14'h30AA;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_exec_w_we", w_we, 0);
    chk("rst_exec_retired", retired, 0);
    @(negedge clk); #1;
    chk("rst_exec_pc", pc, 13'h0000);
    chk("rst_exec_flags", {stk_ovf, stk_unf}, 0);
    rst = 1'b0;
    #1;
    chk("rst_exec_fetch", imem_en, 1);
    model_reset();

    // Random instruction stream.
    for (int n = 0; n < 220; n++) begin
      r = $urandom;
      case ($urandom_range(0, 9))
        0, 9:    ins = {2'b11, r[11:0]};
        1:       ins = {2'b00, r[11:0]};
        2:       ins = {2'b00, (r[12] ? 4'hB : 4'hF), r[7:0]};
        3:       ins = {2'b01, r[11:0]};
        4:       ins = {3'b101, r[10:0]};
        5:       ins = {3'b100, r[10:0]};
        6:       ins = 14'h0008;
        7:       ins = {4'b1101, r[9:0]};
        default: ins = 14'h0000;
      endcase
      if (r[31:29] == 3'b000) idle(int'(r[28:27]) + 1);
      step(ins, r[20]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
